rca_wide_add_arbiter: RTL and testbench

Sequencer and arbiter that shares one 16-bit ripple-carry adder (`RCA_16bit`, instantiated inside) between two requesters. Each request is a `16*WORDS`-bit add. The block runs it least-significant word first, one 16-bit slice per clock, and chains the carry through a register. Two independent requesters issue wide adds through it; a single response port returns the sum, carry-out and requester ID.

---
 rtl/rca_wide_add_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_rca_wide_add_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_wide_add_arbiter.sv
`default_nettype none
// ============================================================================
// rca_wide_add_arbiter : two-requester round-robin sequencer sharing one
// 16-bit ripple-carry adder for WORDS-slice adds. Optional macro: RCA_ARB_SUB_EN
// Revision: 1.0
// ============================================================================

module RCA_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);
  logic [16:0] w_c;

  assign w_c[0] = cin_i;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_fa
      assign sum_o[gi]   = a_i[gi] ^ b_i[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (a_i[gi] & b_i[gi]) | (w_c[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign cout_o = w_c[16];
endmodule

module rca_wide_add_arbiter #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [16*WORDS-1:0]  req0_a,
  input  logic [16*WORDS-1:0]  req0_b,
  input  logic                 req0_cin,
`ifdef RCA_ARB_SUB_EN
  input  logic                 req0_sub,
`endif
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [16*WORDS-1:0]  req1_a,
  input  logic [16*WORDS-1:0]  req1_b,
  input  logic                 req1_cin,
`ifdef RCA_ARB_SUB_EN
  input  logic                 req1_sub,
`endif
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [16*WORDS-1:0]  rsp_sum,
  output logic                 rsp_cout
);
  localparam int WIDTH = 16 * WORDS;
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              c_q, c_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              id_q, id_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;

  logic              w_idle, w_gnt0, w_gnt1;
  logic [15:0]       w_a_slice, w_b_raw, w_b_slice, w_sum;
  logic              w_cout;

  // Requester 1 wins only when it is alone or the pointer prefers it.
  assign w_idle = (state_q == S_IDLE);
  assign w_gnt1 = req1_valid & (~req0_valid | prio_q);
  assign w_gnt0 = req0_valid & ~w_gnt1;

  assign req0_ready = w_idle & w_gnt0 & ~rst;
  assign req1_ready = w_idle & w_gnt1 & ~rst;

  assign w_a_slice = a_q[16*idx_q +: 16];
  assign w_b_raw   = b_q[16*idx_q +: 16];

`ifdef RCA_ARB_SUB_EN
  logic sub_q, sub_d;
  assign w_b_slice = sub_q ? ~w_b_raw : w_b_raw;
`else
  assign w_b_slice = w_b_raw;
`endif

  RCA_16bit u_rca (
    .a_i    (w_a_slice),
    .b_i    (w_b_slice),
    .cin_i  (c_q),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    idx_d   = idx_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef RCA_ARB_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_gnt0 | w_gnt1) begin
          a_d     = w_gnt1 ? req1_a : req0_a;
          b_d     = w_gnt1 ? req1_b : req0_b;
          c_d     = w_gnt1 ? req1_cin : req0_cin;
`ifdef RCA_ARB_SUB_EN
          sub_d   = w_gnt1 ? req1_sub : req0_sub;
          // Two's-complement subtract: invert b per slice and inject the +1.
          if (sub_d) c_d = 1'b1;
`endif
          id_d    = w_gnt1;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[16*idx_q +: 16] = w_sum;
        c_d                   = w_cout;
        idx_d                 = idx_q + IDXW'(1);
        if (idx_q == IDXW'(WORDS - 1)) begin
          cout_d  = w_cout;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          prio_d  = ~id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef RCA_ARB_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef RCA_ARB_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule

`default_nettype wire

// File: tb/tb_rca_wide_add_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rca_wide_add_arbiter : randomized bench with a cycle-level reference model
// of arbitration, latency and wide-add results. Revision: 1.0
// ============================================================================

module tb_rca_wide_add_arbiter;
  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_cin, req1_cin;
`ifdef RCA_ARB_SUB_EN
  logic         req0_sub, req1_sub;
`endif
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  always #5 clk = ~clk;

  rca_wide_add_arbiter #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
`ifdef RCA_ARB_SUB_EN
    .req0_sub   (req0_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
`ifdef RCA_ARB_SUB_EN
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one op in flight, cycles since its handshake.
  bit           m_busy, m_ptr, m_id, m_cout;
  int           m_cnt;
  logic [W-1:0] m_sum;
  bit           acc0, acc1;

  task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [W:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
    logic [W:0] r;
    if (sub) begin
      r[W-1:0] = a - b;
      r[W]     = (a >= b);
    end else begin
      r = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    end
    return r;
  endfunction

  function automatic logic sub_of(input int who);
`ifdef RCA_ARB_SUB_EN
    return (who == 1) ? req1_sub : req0_sub;
`else
    return (who == 1) ? 1'b0 : 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: v = '1;
      1: v = W'($urandom_range(0, 3));
      default: ;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_sum = '0; m_cout = 0;
  endtask

  // One clock: check at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    int g;
    logic [W:0] r;
    @(negedge clk);
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    if (m_busy) m_cnt++;
    g = -1;
    if (!m_busy && (req0_valid || req1_valid))
      g = (req0_valid && req1_valid) ? int'(m_ptr) : (req0_valid ? 0 : 1);
    check_eq("req0_ready", W'(req0_ready), W'(g == 0));
    check_eq("req1_ready", W'(req1_ready), W'(g == 1));
    check_eq("rsp_valid", W'(rsp_valid), W'(m_busy && m_cnt >= WORDS + 1));
    if (m_busy && m_cnt >= WORDS + 1) begin
      check_eq("rsp_id", W'(rsp_id), W'(m_id));
      check_eq("rsp_sum", {1'b0, rsp_sum}, {1'b0, m_sum});
      check_eq("rsp_cout", W'(rsp_cout), W'(m_cout));
    end
    if (m_busy) begin
      if (m_cnt >= WORDS + 1 && rsp_ready) begin
        m_busy = 0;
        m_ptr  = !m_id;
      end
    end else if (g >= 0) begin
      r = (g == 1) ? ref_result(req1_a, req1_b, req1_cin, sub_of(1))
                   : ref_result(req0_a, req0_b, req0_cin, sub_of(0));
      m_busy = 1; m_cnt = 0; m_id = (g == 1);
      m_sum  = r[W-1:0]; m_cout = r[W];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int who, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    if (who == 1) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
`ifdef RCA_ARB_SUB_EN
      req1_sub = sub;
`endif
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
`ifdef RCA_ARB_SUB_EN
      req0_sub = sub;
`endif
    end
    if (sub) ;
  endtask

  task automatic issue(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    int k;
    drive(who, 1'b1, a, b, cin, sub);
    k = 0;
    do begin
      tick();
      k++;
    end while (!((who == 1) ? acc1 : acc0) && k < 100);
    check_eq("accepted", W'((who == 1) ? acc1 : acc0), W'(1));
    // Inputs are scrambled after the handshake: the block must not resample them.
    drive(who, 1'b0, rnd64(), rnd64(), 1'($urandom), 1'b0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_busy && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int order[4];
    int nh, k;
    logic [W:0] r;

    rst = 1'b1; rsp_ready = 0;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_rsp_valid", W'(rsp_valid), '0);
    check_eq("reset_rsp_id", W'(rsp_id), '0);
    check_eq("reset_rsp_sum", {1'b0, rsp_sum}, '0);
    check_eq("reset_rsp_cout", W'(rsp_cout), '0);
    check_eq("reset_ready", W'({req1_ready, req0_ready}), '0);
    rst = 1'b0;
    model_reset();

    // Carry across the first slice boundary.
    rsp_ready = 1;
    issue(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    drain();
    check_eq("slice_carry_sum", {1'b0, rsp_sum}, 65'h0_0000_0000_0001_0000);
    check_eq("slice_carry_cout", W'(rsp_cout), '0);
    check_eq("slice_carry_id", W'(rsp_id), '0);

    // Carry rippling through every slice.
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
    drain();
    check_eq("ripple_sum", {1'b0, rsp_sum}, '0);
    check_eq("ripple_cout", W'(rsp_cout), W'(1));
    check_eq("ripple_id", W'(rsp_id), W'(1));

    // Round-robin with both requesters permanently valid.
    do_reset();
    rsp_ready = 1;
    drive(0, 1'b1, rnd64(), rnd64(), 1'($urandom), 1'b0);
    drive(1, 1'b1, rnd64(), rnd64(), 1'($urandom), 1'b0);
    nh = 0; k = 0;
    while (nh < 4 && k < 100) begin
      tick();
      k++;
      if (acc0 || acc1) begin
        order[nh] = acc1 ? 1 : 0;
        nh++;
        if (acc0) drive(0, 1'b1, rnd64(), rnd64(), 1'($urandom), 1'b0);
        if (acc1) drive(1, 1'b1, rnd64(), rnd64(), 1'($urandom), 1'b0);
      end
    end
    check_eq("rr_grants", W'(nh), W'(4));
    for (int i = 0; i < 4; i++) check_eq("rr_order", W'(order[i]), W'(i % 2));
    req0_valid = 0; req1_valid = 0;
    drain();

    // Response backpressure, then a waiting requester is accepted right after.
    rsp_ready = 0;
    issue(0, rnd64(), rnd64(), 1'b0, 1'b0);
    k = 0;
    while (!rsp_valid && k < 20) begin tick(); k++; end
    check_eq("bp_rsp_valid", W'(rsp_valid), W'(1));
    drive(1, 1'b1, rnd64(), rnd64(), 1'b1, 1'b0);
    repeat (3) tick();
    rsp_ready = 1;
    k = 0;
    do begin tick(); k++; end while (!acc1 && k < 10);
    check_eq("bp_next_accept", W'(acc1), W'(1));
    check_eq("bp_next_latency", W'(k), W'(2));
    req1_valid = 0;
    drain();

    // Reset during the second ADD cycle drops the op.
    issue(1, rnd64(), rnd64(), 1'b1, 1'b0);
    tick();
    req0_valid = 1;
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", W'({req1_ready, req0_ready}), '0);
    check_eq("midrst_rsp_valid", W'(rsp_valid), '0);
    check_eq("midrst_rsp_sum", {1'b0, rsp_sum}, '0);
    check_eq("midrst_rsp_id_cout", W'({rsp_id, rsp_cout}), '0);
    req0_valid = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (8) tick();
    drive(0, 1'b1, rnd64(), rnd64(), 1'b0, 1'b0);
    drive(1, 1'b1, rnd64(), rnd64(), 1'b0, 1'b0);
    tick();
    check_eq("post_reset_grant0", W'(acc0), W'(1));
    req0_valid = 0; req1_valid = 0;
    drain();

`ifdef RCA_ARB_SUB_EN
    issue(0, 64'd5, 64'd7, 1'b0, 1'b1);
    drain();
    check_eq("sub_neg_sum", {1'b0, rsp_sum}, 65'h0_FFFF_FFFF_FFFF_FFFE);
    check_eq("sub_neg_cout", W'(rsp_cout), '0);
    issue(0, 64'd7, 64'd5, 1'b0, 1'b1);
    drain();
    check_eq("sub_pos_sum", {1'b0, rsp_sum}, 65'd2);
    check_eq("sub_pos_cout", W'(rsp_cout), W'(1));
`endif

    // Random traffic: requesters hold their request until accepted.
    for (int n = 0; n < 400; n++) begin
      tick();
      if (acc0 || !req0_valid)
        drive(0, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'($urandom), 1'($urandom));
      if (acc1 || !req1_valid)
        drive(1, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 1'($urandom), 1'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    drain();
    r = '0;
    if (r != '0) ;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
